// File: rtl/io_pkg.sv
// Shared I/O-device constants: bus width, timer register addresses and TCTL bit layout.
// Imported by the timer, its bus interface and the bench.
package io_pkg;

    localparam int DBITS = 32;

    localparam logic [DBITS-1:0] ADDR_TCNT = 32'hF000_0020;
    localparam logic [DBITS-1:0] ADDR_TLIM = 32'hF000_0024;
    localparam logic [DBITS-1:0] ADDR_TCTL = 32'hF000_0120;

    localparam int TCTL_READY = 0;
    localparam int TCTL_OVR   = 2;
    localparam int TCTL_IE    = 8;

    // Reserved bits (including bit 1) always read back as zero.
    function automatic logic [DBITS-1:0] packTctl(input logic ready,
                                                  input logic ovr,
                                                  input logic ie);
        logic [DBITS-1:0] v;
        v             = '0;
        v[TCTL_READY] = ready;
        v[TCTL_OVR]   = ovr;
        v[TCTL_IE]    = ie;
        return v;
    endfunction

endpackage

// File: rtl/io_timer_if.sv
// Processor I/O bus as seen by one memory-mapped device.
// master = memory stage / I/O controller side, slave = device side.
interface io_timer_if;
    import io_pkg::*;

    logic [DBITS-1:0] abus;
    logic [DBITS-1:0] dbus_in;
    logic             we;
    logic [DBITS-1:0] dbus_out;
    logic             dbus_oe;

    modport master (
        output abus, dbus_in, we,
        input  dbus_out, dbus_oe
    );

    modport slave (
        input  abus, dbus_in, we,
        output dbus_out, dbus_oe
    );

endinterface

// File: rtl/timer_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_PER_MS cycles.
// clr restarts the divide period from zero on the next edge.
module timer_prescaler #(
    parameter int CLK_PER_MS = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

    logic [W-1:0] preCnt;

    assign tick = (preCnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + 1'b1;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped millisecond timer: count, limit/wrap and sticky ready/overrun flags.
// Zero-latency combinational reads; TIMER_IRQ_EN adds TCTL interrupt enable and a registered irq output.
module io_timer
    import io_pkg::*;
#(
    parameter int CLK_PER_MS = 5000
) (
    input  logic       clk,
    input  logic       rst,
    io_timer_if.slave  bus
`ifdef TIMER_IRQ_EN
    ,
    output logic       irq
`endif
);

    logic [DBITS-1:0] tcnt;
    logic [DBITS-1:0] tlim;
    logic             ready;
    logic             ovr;
    logic             ieBit;
    logic             tick;

    logic hitCnt, hitLim, hitCtl;
    logic wrCnt, wrLim, wrCtl;
    logic clrReady, clrOvr;
    logic wrapEv;

    assign hitCnt = (bus.abus == ADDR_TCNT);
    assign hitLim = (bus.abus == ADDR_TLIM);
    assign hitCtl = (bus.abus == ADDR_TCTL);

    assign wrCnt = bus.we && hitCnt;
    assign wrLim = bus.we && hitLim;
    assign wrCtl = bus.we && hitCtl;

    assign clrReady = wrCtl && !bus.dbus_in[TCTL_READY];
    assign clrOvr   = wrCtl && !bus.dbus_in[TCTL_OVR];

    // A count write swallows a coincident tick, so no wrap may fire from it.
    assign wrapEv = tick && !wrCnt && (tlim != '0) && (tcnt == tlim - 1'b1);

    timer_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) uPrescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (wrCnt),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (wrCnt) begin
            tcnt <= bus.dbus_in;
        end else if (tick) begin
            tcnt <= wrapEv ? '0 : tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tlim <= '0;
        end else if (wrLim) begin
            tlim <= bus.dbus_in;
        end
    end

    // Set beats clear; a wrap that lands on a ready-clear re-arms ready without flagging overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (wrapEv) begin
                ready <= 1'b1;
            end else if (clrReady) begin
                ready <= 1'b0;
            end

            if (wrapEv && ready && !clrReady) begin
                ovr <= 1'b1;
            end else if (clrOvr) begin
                ovr <= 1'b0;
            end
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ieBit <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wrCtl) begin
                ieBit <= bus.dbus_in[TCTL_IE];
            end
            irq <= ready && ieBit;
        end
    end
`else
    assign ieBit = 1'b0;
`endif

    always_comb begin
        bus.dbus_oe  = !bus.we && (hitCnt || hitLim || hitCtl);
        bus.dbus_out = '0;
        if (bus.dbus_oe) begin
            if (hitCnt) begin
                bus.dbus_out = tcnt;
            end else if (hitLim) begin
                bus.dbus_out = tlim;
            end else begin
                bus.dbus_out = packTctl(ready, ovr, ieBit);
            end
        end
    end

endmodule
